// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 encodings, writeback
// select codes, FSM state and the MEM/WB register layout.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] mem_data;
  } memwb_t;

  // Illegal size encodings are reported as misaligned so they are squashed too.
  function automatic logic access_misaligned(input logic       is_store,
                                             input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic legal;
    if (is_store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                          (f3 == F3_BU) || (f3 == F3_HU);
    return !legal || ((f3[1:0] == 2'b01) && lo[0]) ||
           ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/half lane from the read word and
// sign- or zero-extends it according to funct3.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_w = rdata_i[7:0];
      2'd1:    byte_w = rdata_i[15:8];
      2'd2:    byte_w = rdata_i[23:16];
      default: byte_w = rdata_i[31:24];
    endcase
    half_w = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_w[7]}}, byte_w};
      F3_H:    data_o = {{16{half_w[15]}}, half_w};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'h0, byte_w};
      F3_HU:   data_o = {16'h0, half_w};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory req/ack bus, stalls
// upstream while an access is outstanding and registers the MEM/WB slot.
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] pc_address_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_result_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] pc_address_o,
  output logic        mem_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [29:0] addr_q;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  memwb_t      wb_q, wb_d;
  logic        misalign_q, bus_err_q;

  logic        mem_op, misalign, issue, timeout, ack_done;
  logic [31:0] ld_data;

  assign mem_op   = valid_i & (memread_i | memwrite_i);
  assign misalign = mem_op & access_misaligned(memwrite_i, funct3_i, alu_result_i[1:0]);
  assign issue    = (state_q == ST_IDLE) & mem_op & ~misalign;
  assign ack_done = (state_q == ST_BUSY) & dmem_ack_i;
  assign timeout  = (state_q == ST_BUSY) & ~dmem_ack_i & (cnt_q == TO_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; ack is tested before timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (dmem_ack_i || timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_o    = issue | ((state_q == ST_BUSY) & ~dmem_ack_i & ~timeout);
    dmem_req_o = (state_q == ST_BUSY);
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_d = {4{rs2_data_i[7:0]}};
      2'b01:   wdata_d = {2{rs2_data_i[15:0]}};
      default: wdata_d = rs2_data_i;
    endcase
    case (funct3_i[1:0])
      2'b00:   be_d = 4'b0001 << alu_result_i[1:0];
      2'b01:   be_d = alu_result_i[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      lo_q    <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (issue) begin
      we_q    <= memwrite_i;
      addr_q  <= alu_result_i[31:2];
      lo_q    <= alu_result_i[1:0];
      f3_q    <= funct3_i;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  load_align u_load_align (
    .funct3_i  (f3_q),
    .addr_lo_i (lo_q),
    .rdata_i   (dmem_rdata_i),
    .data_o    (ld_data)
  );

  // Upstream fields are still valid on ack because EX/MEM was held by stall_o.
  always_comb begin
    wb_d = '0;
    if (((state_q == ST_IDLE) && valid_i && !mem_op) || ack_done) begin
      wb_d.valid    = 1'b1;
      wb_d.regwrite = regwrite_i;
      wb_d.rd       = rd_addr_i;
      wb_d.wb_sel   = wb_sel_i;
      wb_d.alu      = alu_result_i;
      wb_d.pc       = pc_address_i;
      wb_d.mem_data = (ack_done && !we_q) ? ld_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      misalign_q <= (state_q == ST_IDLE) & misalign;
      bus_err_q  <= timeout;
    end
  end

  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q, 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

  assign mem_valid_o  = wb_q.valid;
  assign regwrite_o   = wb_q.regwrite;
  assign rd_addr_o    = wb_q.rd;
  assign wb_sel_o     = wb_q.wb_sel;
  assign alu_result_o = wb_q.alu;
  assign pc_address_o = wb_q.pc;
  assign mem_data_o   = wb_q.mem_data;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized mix
// checked against a behavioural model of the access rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, memread_i, memwrite_i, regwrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_address_i, dmem_rdata_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  wb_sel_i;
  logic        dmem_ack_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, mem_data_o, alu_result_o, pc_address_o;
  logic [3:0]  dmem_be_o;
  logic        regwrite_o, mem_valid_o, misalign_o, bus_err_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  wb_sel_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .regwrite_i(regwrite_i), .rd_addr_i(rd_addr_i),
    .wb_sel_i(wb_sel_i), .pc_address_i(pc_address_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i(dmem_ack_i), .mem_data_o(mem_data_o), .alu_result_o(alu_result_o),
    .regwrite_o(regwrite_o), .rd_addr_o(rd_addr_o), .wb_sel_o(wb_sel_o),
    .pc_address_o(pc_address_o), .mem_valid_o(mem_valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_misaligned(input logic st, input logic [2:0] f3,
                                          input logic [31:0] a);
    int unsigned size;
    if (st) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (f3 == 3'd3 || f3 > 3'd5) begin
      return 1'b1;
    end
    size = 1 << (f3 % 4);
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: v = (rd >> (8 * (a % 4))) & 32'hFF;
      3'd1, 3'd5: v = (rd >> (8 * (a & 2))) & 32'hFFFF;
      default:    v = rd;
    endcase
    if (f3 == 3'd0 && v >= 32'h80)   v = v + 32'hFFFFFF00;
    if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic idle_inputs();
    valid_i = 0; memread_i = 0; memwrite_i = 0; regwrite_i = 0;
    funct3_i = 0; alu_result_i = 0; rs2_data_i = 0; rd_addr_i = 0;
    wb_sel_i = 0; pc_address_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    n_cmp++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_bus stall=%b req=%b want 0/0", stall_o, dmem_req_o); end
    n_cmp++; if ({dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o} !== '0) begin n_bad++; $display("FAIL reset_dmem got we=%b addr=%h wdata=%h be=%b want all 0", dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o); end
    n_cmp++; if ({mem_data_o, alu_result_o, regwrite_o, rd_addr_o, wb_sel_o, pc_address_o} !== '0) begin n_bad++; $display("FAIL reset_memwb got data=%h alu=%h rw=%b rd=%0d wb=%b pc=%h want all 0", mem_data_o, alu_result_o, regwrite_o, rd_addr_o, wb_sel_o, pc_address_o); end
    n_cmp++; if ({mem_valid_o, misalign_o, bus_err_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got v=%b mis=%b err=%b want 000", mem_valid_o, misalign_o, bus_err_o); end
    rst_n = 1;
    tick();
  endtask

  task automatic run_alu(input logic [31:0] res, input logic [1:0] wbs, input string name);
    logic [4:0] rd; logic [31:0] pc; logic rw;
    rd = 5'($urandom_range(1, 31)); pc = $urandom & 32'hFFFFFFFC; rw = 1'($urandom);
    valid_i = 1; memread_i = 0; memwrite_i = 0; funct3_i = 3'($urandom);
    alu_result_i = res; wb_sel_i = wbs; regwrite_i = rw; rd_addr_i = rd; pc_address_i = pc;
    #1;
    n_cmp++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL %s stall=%b req=%b want 0/0", name, stall_o, dmem_req_o); end
    tick();
    valid_i = 0;
    n_cmp++; if (mem_valid_o !== 1'b1 || alu_result_o !== res) begin n_bad++; $display("FAIL %s result v=%b alu=%h want 1/%h", name, mem_valid_o, alu_result_o, res); end
    n_cmp++; if (rd_addr_o !== rd || wb_sel_o !== wbs || pc_address_o !== pc || regwrite_o !== rw) begin n_bad++; $display("FAIL %s fields rd=%0d wb=%b pc=%h rw=%b want %0d/%b/%h/%b", name, rd_addr_o, wb_sel_o, pc_address_o, regwrite_o, rd, wbs, pc, rw); end
    n_cmp++; if (mem_data_o !== 32'h0) begin n_bad++; $display("FAIL %s mem_data got %h want 0", name, mem_data_o); end
  endtask

  task automatic run_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdat,
                         input int unsigned nwait, input string name);
    int unsigned stalls;
    logic [4:0] rd; logic [31:0] pc; logic [31:0] want;
    rd = 5'($urandom_range(1, 31)); pc = $urandom & 32'hFFFFFFFC;
    valid_i = 1; memread_i = ~st; memwrite_i = st; funct3_i = f3; alu_result_i = addr;
    rs2_data_i = rs2; regwrite_i = ~st; rd_addr_i = rd; wb_sel_i = st ? 2'b00 : 2'b01;
    pc_address_i = pc;
    #1;
    n_cmp++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL %s issue stall=%b req=%b want 1/0", name, stall_o, dmem_req_o); end
    stalls = (stall_o === 1'b1) ? 1 : 0;
    tick();
    for (int unsigned k = 0; k <= nwait; k++) begin
      if (k == nwait) begin dmem_ack_i = 1; dmem_rdata_i = rdat; end
      else dmem_rdata_i = $urandom;
      #1;
      if (stall_o === 1'b1) stalls++;
      n_cmp++; if (dmem_req_o !== 1'b1 || dmem_we_o !== st || dmem_addr_o !== (addr & 32'hFFFFFFFC)) begin n_bad++; $display("FAIL %s bus k=%0d req=%b we=%b addr=%h want 1/%b/%h", name, k, dmem_req_o, dmem_we_o, dmem_addr_o, st, addr & 32'hFFFFFFFC); end
      if (st) begin
        n_cmp++; if (dmem_be_o !== exp_be(f3, addr) || dmem_wdata_o !== exp_wdata(f3, rs2)) begin n_bad++; $display("FAIL %s wr k=%0d be=%b wdata=%h want %b/%h", name, k, dmem_be_o, dmem_wdata_o, exp_be(f3, addr), exp_wdata(f3, rs2)); end
      end
      tick();
    end
    dmem_ack_i = 0; valid_i = 0;
    want = st ? 32'h0 : exp_load(f3, addr, rdat);
    n_cmp++; if (stalls != nwait + 1) begin n_bad++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, nwait + 1); end
    n_cmp++; if (mem_valid_o !== 1'b1 || mem_data_o !== want) begin n_bad++; $display("FAIL %s wb v=%b data=%h want 1/%h", name, mem_valid_o, mem_data_o, want); end
    n_cmp++; if (regwrite_o !== ~st || rd_addr_o !== rd || alu_result_o !== addr || pc_address_o !== pc || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL %s wb_fields rw=%b rd=%0d alu=%h pc=%h req=%b want %b/%0d/%h/%h/0", name, regwrite_o, rd_addr_o, alu_result_o, pc_address_o, dmem_req_o, ~st, rd, addr, pc); end
  endtask

  task automatic run_misalign(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input string name);
    valid_i = 1; memread_i = ~st; memwrite_i = st; funct3_i = f3; alu_result_i = addr;
    rs2_data_i = $urandom; regwrite_i = 1; rd_addr_i = 5'd7; wb_sel_i = 2'b01;
    pc_address_i = 32'h400;
    #1;
    n_cmp++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL %s stall=%b req=%b want 0/0", name, stall_o, dmem_req_o); end
    tick();
    valid_i = 0;
    n_cmp++; if (misalign_o !== 1'b1 || mem_valid_o !== 1'b0 || regwrite_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL %s squash mis=%b v=%b rw=%b req=%b want 1/0/0/0", name, misalign_o, mem_valid_o, regwrite_o, dmem_req_o); end
    tick();
    n_cmp++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL %s pulse mis=%b want 0", name, misalign_o); end
  endtask

  task automatic test_alu();
    run_alu(32'h00000010, 2'b00, "add");
    for (int i = 0; i < 4; i++) run_alu($urandom, 2'($urandom_range(0, 2)), "alu_rand");
  endtask

  task automatic test_loads();
    run_mem(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 3, "lb");
    run_mem(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 3, "lbu");
    run_mem(1'b0, 3'd1, 32'h102, 32'h0, 32'h9ABC5678, 0, "lh_min");
    run_mem(1'b0, 3'd5, 32'h102, 32'h0, 32'h9ABC5678, 1, "lhu");
    run_mem(1'b0, 3'd2, 32'h104, 32'h0, 32'hDEADBEEF, 2, "lw");
  endtask

  task automatic test_stores();
    run_mem(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, "sh");
    run_mem(1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 0, "sb");
    run_mem(1'b1, 3'd2, 32'h308, 32'hCAFEF00D, 32'h0, 2, "sw");
  endtask

  task automatic test_misalign();
    run_misalign(1'b0, 3'd2, 32'h101, "lw_mis");
    run_misalign(1'b1, 3'd1, 32'h203, "sh_mis");
    run_misalign(1'b0, 3'd3, 32'h100, "ld_illegal");
    run_misalign(1'b1, 3'd4, 32'h100, "st_illegal");
  endtask

  task automatic test_timeout();
    int unsigned busy;
    logic released;
    busy = 0; released = 0;
    valid_i = 1; memread_i = 0; memwrite_i = 1; funct3_i = 3'd2; alu_result_i = 32'h500;
    rs2_data_i = 32'h11223344; regwrite_i = 0; rd_addr_i = 0; wb_sel_i = 0;
    tick();
    for (int unsigned c = 1; c <= 40 && !released; c++) begin
      #1;
      busy = c;
      if (stall_o === 1'b0) begin
        released = 1;
        n_cmp++; if (dmem_req_o !== 1'b1 || bus_err_o !== 1'b0) begin n_bad++; $display("FAIL timeout_release req=%b err=%b want 1/0", dmem_req_o, bus_err_o); end
      end
      tick();
    end
    valid_i = 0;
    n_cmp++; if (!released || busy != 16) begin n_bad++; $display("FAIL timeout_cycles got %0d released=%b want 16", busy, released); end
    n_cmp++; if (bus_err_o !== 1'b1 || mem_valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL timeout_err err=%b v=%b req=%b want 1/0/0", bus_err_o, mem_valid_o, dmem_req_o); end
    tick();
    n_cmp++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse err=%b want 0", bus_err_o); end
  endtask

  task automatic test_reset_busy();
    valid_i = 1; memread_i = 1; memwrite_i = 0; funct3_i = 3'd2; alu_result_i = 32'h600;
    regwrite_i = 1; rd_addr_i = 5'd9; wb_sel_i = 2'b01;
    tick(); tick();
    valid_i = 0; rst_n = 0;
    tick();
    n_cmp++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_valid_o !== 1'b0 || dmem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_busy req=%b stall=%b v=%b addr=%h want 0/0/0/0", dmem_req_o, stall_o, mem_valid_o, dmem_addr_o); end
    rst_n = 1; dmem_ack_i = 1; dmem_rdata_i = 32'h55AA55AA;
    tick();
    dmem_ack_i = 0;
    n_cmp++; if (mem_valid_o !== 1'b0 || mem_data_o !== 32'h0 || regwrite_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_bad++; $display("FAIL late_ack v=%b data=%h rw=%b req=%b want 0/0/0/0", mem_valid_o, mem_data_o, regwrite_o, dmem_req_o); end
  endtask

  task automatic test_back_to_back();
    logic st; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: run_alu($urandom, 2'($urandom_range(0, 2)), "b2b_alu");
        1, 2: begin
          st = 1'($urandom);
          f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
          if (f3 == 3'd3) f3 = 3'd2;
          a = $urandom & ~((32'd1 << (f3 % 4)) - 1);
          run_mem(st, f3, a, $urandom, $urandom, $urandom_range(0, 5), "b2b_mem");
        end
        default: begin
          st = 1'($urandom); f3 = 3'($urandom); a = $urandom;
          if (exp_misaligned(st, f3, a)) run_misalign(st, f3, a, "b2b_mis");
          else run_mem(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), "b2b_ok");
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between EX and WB.
- Issues loads and stores to the data memory over a req/ack bus and stalls upstream while an access is outstanding.
- Aligns and extends load data, then registers the MEM/WB pipeline signals consumed by the writeback stage.
- Detects misaligned accesses and bus timeouts and squashes the affected instruction.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in BUSY without dmem_ack_i before bus_err_o; range 2..255.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  EX/MEM holds a valid instruction
- memread_i  in  1  load
- memwrite_i  in  1  store
- funct3_i  in  3  access size/sign (RV32I encoding)
- alu_result_i  in  32  effective address / ALU result
- rs2_data_i  in  32  store data
- regwrite_i  in  1  instruction writes rd
- rd_addr_i  in  5  destination register
- wb_sel_i  in  2  00 ALU, 01 MEM, 10 PC+4 (passed through)
- pc_address_i  in  32  instruction PC
- stall_o  out  1  hold EX/MEM and earlier stages
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  32  lane-replicated write data
- dmem_be_o  out  4  byte enables
- dmem_rdata_i  in  32  read data, valid with ack
- dmem_ack_i  in  1  access complete
- mem_data_o  out  32  aligned/extended load data
- alu_result_o  out  32  registered alu_result_i
- regwrite_o  out  1  registered, cleared on bubble/fault
- rd_addr_o  out  5  registered
- wb_sel_o  out  2  registered
- pc_address_o  out  32  registered
- mem_valid_o  out  1  MEM/WB slot holds a valid instruction
- misalign_o  out  1  one-cycle pulse, registered
- bus_err_o  out  1  one-cycle pulse, registered

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, timeout counter=0, all outputs 0. dmem_req_o drops the following cycle. An in-flight access is abandoned, and a late ack after reset is ignored.
- mem_op = valid_i & (memread_i | memwrite_i).
- Alignment: mem_op is misaligned if half (funct3[1:0]=01) with addr[0]=1, or word (010) with addr[1:0]!=0. Load funct3 011/110/111 and store funct3 other than 000/001/010 are treated as misaligned.
- FSM states: IDLE, BUSY.
- IDLE, non-mem valid instruction:
  - latency 1; MEM/WB registers load the inputs; mem_valid_o=1; stall_o=0.
- IDLE, misaligned mem_op:
  - no bus request, no stall; next cycle mem_valid_o=0, regwrite_o=0, misalign_o=1.
- IDLE, aligned mem_op:
  - latch we/addr/wdata/be/funct3/addr[1:0]; go to BUSY.
  - stall_o=1 combinationally this cycle.
  - MEM/WB gets a bubble: mem_valid_o=0, regwrite_o=0.
- IDLE, valid_i=0: bubble.
- BUSY:
  - dmem_req_o=1 with latched fields, held stable until ack.
  - stall_o = ~dmem_ack_i & ~timeout.
  - On dmem_ack_i: MEM/WB loads the upstream fields, which are unchanged because the stage was stalled, plus extracted load data; mem_valid_o=1; return to IDLE.
  - Minimum load/store latency is 2 cycles.
  - Counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES-1 without ack: bus_err_o=1, bubble, IDLE, counter cleared.
  - Ack and timeout in the same cycle: ack wins.
- Write data:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: be=4'b1111.
- Load data: select byte lane addr[1:0] or half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
  - Stores: mem_data_o=0.
- mem_data_o is 0 on bubbles.
- dmem_we_o=0 for loads.

Decomposition:
- Shared package rv32i_pkg: funct3 encodings (F3_B/H/W/BU/HU), wb_sel codes (WB_ALU/MEM/PC4), FSM state enum.
- One sub-module: load_align (combinational lane select plus sign/zero extend from funct3 and addr[1:0]).

Test Plan:
- ADD result 0x00000010, wb_sel=00, valid_i=1 -> next cycle mem_valid_o=1, alu_result_o=0x10, stall_o=0 throughout.
- LB addr 0x103, ack after 3 BUSY cycles with rdata 0x80_11_22_33 -> stall_o high 4 cycles, then mem_data_o=0xFFFFFF80, mem_valid_o=1; LBU same -> 0x00000080.
- SH addr 0x202, rs2=0x1234ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x200, dmem_we_o=1.
- LW addr 0x101 -> no dmem_req_o, stall_o=0, next cycle misalign_o=1, regwrite_o=0, mem_valid_o=0.
- SW with no ack, TIMEOUT_CYCLES=16 -> bus_err_o pulses once after 16 BUSY cycles, stall_o released the same cycle.
- rst_n=0 during BUSY, then an ack arrives -> state IDLE, dmem_req_o=0 the following cycle, all outputs 0, ack ignored.
